// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO behind a UART receiver
// Entries carry {par_err, stp_err, payload}. The FIFO tracks overrun and counts dropped error frames.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     data_valid,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     par_err,
    input  logic                     stp_err,
    input  logic                     drop_err_en,
    input  logic                     rd_ready,
    input  logic                     ovr_clr,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_par_err,
    output logic                     rd_stp_err,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic [7:0]    r_drop_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_has_err;
    logic          w_drop;
    logic          w_wr_req;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic          w_ovr_set;
    logic [EW-1:0] w_head;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_has_err = par_err | stp_err;

    // Errored frames are discarded before the full check, so they never count as overruns.
    assign w_drop    = data_valid & drop_err_en & w_has_err;
    assign w_wr_req  = data_valid & ~w_drop;
    assign w_rd_fire = ~w_empty & rd_ready;
    assign w_wr_fire = w_wr_req & (~w_full | w_rd_fire);
    assign w_ovr_set = w_wr_req & w_full & ~w_rd_fire;

    always_ff @(posedge CLK) begin
        if (!RST && w_wr_fire) begin
            r_mem[r_wr_ptr] <= {par_err, stp_err, P_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A fresh overrun wins over a same-cycle clear.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign rd_valid   = ~w_empty;
    assign rd_data    = w_head[DATA_WIDTH-1:0];
    assign rd_stp_err = w_head[DATA_WIDTH];
    assign rd_par_err = w_head[DATA_WIDTH+1];
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign overrun    = r_overrun;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          data_valid = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic          drop_err_en = 1'b0;
    logic          rd_ready = 1'b0;
    logic          ovr_clr = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_par_err;
    logic          rd_stp_err;
    logic          full;
    logic          empty;
    logic [$clog2(DEPTH):0] count;
    logic          overrun;
    logic [7:0]    drop_cnt;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .data_valid(data_valid), .P_DATA(P_DATA),
        .par_err(par_err), .stp_err(stp_err), .drop_err_en(drop_err_en),
        .rd_ready(rd_ready), .ovr_clr(ovr_clr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_stp_err(rd_stp_err),
        .full(full), .empty(empty), .count(count), .overrun(overrun),
        .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: a queue of {par, stp, data} entries plus the two status values.
    logic [DW+1:0] mq[$];
    logic          m_ovr  = 1'b0;
    int            m_drop = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic dv, input logic [DW-1:0] d,
                                input logic pe, input logic se, input logic den,
                                input logic rdy, input logic clr);
        bit was_full, rd_fire, ovr_new;
        if (rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_drop = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        rd_fire  = (mq.size() != 0) && rdy;
        ovr_new  = 1'b0;
        if (rd_fire) void'(mq.pop_front());
        if (dv) begin
            if (den && (pe || se)) begin
                if (m_drop < 255) m_drop++;
            end else if (!was_full || rd_fire) begin
                mq.push_back({pe, se, d});
            end else begin
                ovr_new = 1'b1;
            end
        end
        if (ovr_new) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check_model();
        cmp("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        cmp("count", 32'(count), 32'(mq.size()));
        cmp("full", 32'(full), 32'(mq.size() == DEPTH));
        cmp("empty", 32'(empty), 32'(mq.size() == 0));
        cmp("overrun", 32'(overrun), 32'(m_ovr));
        cmp("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (mq.size() != 0) begin
            cmp("rd_data", 32'(rd_data), 32'(mq[0][DW-1:0]));
            cmp("rd_stp_err", 32'(rd_stp_err), 32'(mq[0][DW]));
            cmp("rd_par_err", 32'(rd_par_err), 32'(mq[0][DW+1]));
        end
    endtask

    task automatic step(input logic rst, input logic dv, input logic [DW-1:0] d,
                        input logic pe, input logic se, input logic den,
                        input logic rdy, input logic clr);
        RST = rst; data_valid = dv; P_DATA = d; par_err = pe; stp_err = se;
        drop_err_en = den; rd_ready = rdy; ovr_clr = clr;
        @(posedge CLK);
        model_update(rst, dv, d, pe, se, den, rdy, clr);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_expect(input logic [DW-1:0] d);
        cmp("seq_head_valid", 32'(rd_valid), 32'd1);
        cmp("seq_head_data", 32'(rd_data), 32'(d));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic rst, dv; logic [7:0] d; logic pe, se, den, rdy, clr;
        int e_cnt; logic e_val; logic [7:0] e_data; logic e_pe, e_se, e_ovr; int e_drop;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0, 0,1'b0,8'h00,1'b0,1'b0,1'b0,0};
        tbl[1]  = '{1'b0,1'b1,8'hA5,1'b0,1'b0,1'b0,1'b0,1'b0, 1,1'b1,8'hA5,1'b0,1'b0,1'b0,0};
        tbl[2]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 0,1'b0,8'h00,1'b0,1'b0,1'b0,0};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 0,1'b0,8'h00,1'b0,1'b0,1'b0,0};
        tbl[4]  = '{1'b0,1'b1,8'h3C,1'b1,1'b0,1'b0,1'b0,1'b0, 1,1'b1,8'h3C,1'b1,1'b0,1'b0,0};
        tbl[5]  = '{1'b0,1'b1,8'h11,1'b0,1'b1,1'b1,1'b0,1'b0, 1,1'b1,8'h3C,1'b1,1'b0,1'b0,1};
        tbl[6]  = '{1'b0,1'b1,8'h22,1'b0,1'b0,1'b1,1'b0,1'b0, 2,1'b1,8'h3C,1'b1,1'b0,1'b0,1};
        tbl[7]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 1,1'b1,8'h22,1'b0,1'b0,1'b0,1};
        tbl[8]  = '{1'b0,1'b0,8'h77,1'b1,1'b1,1'b0,1'b0,1'b0, 1,1'b1,8'h22,1'b0,1'b0,1'b0,1};
        tbl[9]  = '{1'b0,1'b1,8'h5A,1'b1,1'b1,1'b0,1'b1,1'b0, 1,1'b1,8'h5A,1'b1,1'b1,1'b0,1};
        tbl[10] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0, 0,1'b0,8'h00,1'b0,1'b0,1'b0,1};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].dv, tbl[i].d, tbl[i].pe, tbl[i].se, tbl[i].den,
                 tbl[i].rdy, tbl[i].clr);
            cmp($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            cmp($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_val));
            cmp($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            cmp($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
            if (tbl[i].e_val) begin
                cmp($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].e_data));
                cmp($sformatf("vec%0d_rd_par_err", i), 32'(rd_par_err), 32'(tbl[i].e_pe));
                cmp($sformatf("vec%0d_rd_stp_err", i), 32'(rd_stp_err), 32'(tbl[i].e_se));
            end
        end

        // Fill and wrap
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'(i));
        cmp("fill_full", 32'(full), 32'd1);
        cmp("fill_count", 32'(count), 32'd8);
        for (int i = 0; i < 4; i++) rd_expect(8'(i));
        for (int i = 8; i < 12; i++) wr(8'(i));
        for (int i = 4; i < 12; i++) rd_expect(8'(i));
        cmp("wrap_empty", 32'(empty), 32'd1);

        // Overrun, then clear; then overrun coinciding with clear
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'(i));
        wr(8'h55);
        cmp("ovr_set", 32'(overrun), 32'd1);
        cmp("ovr_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) rd_expect(8'(i));
        cmp("ovr_drained", 32'(empty), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("ovr_cleared", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) wr(8'(i));
        step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("ovr_clr_collide", 32'(overrun), 32'd1);

        // Full with simultaneous read and write
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'(i));
        step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("fullrw_count", 32'(count), 32'd8);
        cmp("fullrw_ovr", 32'(overrun), 32'd0);
        for (int i = 1; i < 8; i++) rd_expect(8'(i));
        rd_expect(8'h99);

        // Drop counter saturation, also while full (no overrun from dropped frames)
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'(i));
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cmp("drop_sat", 32'(drop_cnt), 32'd255);
        cmp("drop_no_ovr", 32'(overrun), 32'd0);
        cmp("drop_count", 32'(count), 32'd8);

        // Reset mid-operation with a coincident write
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'(i));
        wr(8'hEE);
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rd_expect(8'(i));
        cmp("pre_rst_count", 32'(count), 32'd5);
        step(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cmp("rst_count", 32'(count), 32'd0);
        cmp("rst_empty", 32'(empty), 32'd1);
        cmp("rst_ovr", 32'(overrun), 32'd0);
        cmp("rst_drop", 32'(drop_cnt), 32'd0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            step(1'b0 || ($urandom_range(199) == 0),
                 ($urandom_range(1) == 1),
                 8'($urandom),
                 ($urandom_range(4) == 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(1) == 1),
                 ($urandom_range(9) < 4),
                 ($urandom_range(9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 8, frame payload width.
- DEPTH, 8, entry count; power of two, minimum 2.
REQ-002 SHALL have ports, one per line:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- data_valid  in  1  one-cycle frame-done strobe from the UART receiver.
- P_DATA  in  DATA_WIDTH  received payload; qualified by data_valid.
- par_err  in  1  parity error of the frame; qualified by data_valid.
- stp_err  in  1  stop error of the frame; qualified by data_valid.
- drop_err_en  in  1  when 1, frames with any error are discarded.
- rd_ready  in  1  consumer accepts the head entry.
- ovr_clr  in  1  clears the overrun flag.
- rd_valid  out  1  head entry present.
- rd_data  out  DATA_WIDTH  head payload.
- rd_par_err  out  1  head parity-error tag.
- rd_stp_err  out  1  head stop-error tag.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupancy.
- overrun  out  1  sticky; a frame was lost because the FIFO was full.
- drop_cnt  out  8  number of error frames discarded; saturating.

Function
REQ-003 SHALL store each entry as {par_err, stp_err, P_DATA}, DATA_WIDTH+2 bits, in a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-004 SHALL treat a frame as "write request" when data_valid=1; it is accepted when (drop_err_en=0 or par_err|stp_err=0) and (full=0 or read fires in the same cycle).
REQ-005 SHALL fire a read when rd_valid=1 and rd_ready=1; rd_ready while empty SHALL be ignored with no pointer or count change.
REQ-006 SHALL operate first-word-fall-through: rd_valid=~empty; rd_data, rd_par_err and rd_stp_err SHALL combinationally reflect the entry at the read pointer.
REQ-007 SHALL have a write-to-rd_valid latency of 1 cycle: an accepted write into an empty FIFO SHALL raise rd_valid on the next edge, with no same-cycle bypass.
REQ-008 SHALL update count by +1 on write only, -1 on read only, and 0 on simultaneous write and read, including the full case.
REQ-009 SHALL drop a write request when full=1 and no read fires; it SHALL then set overrun=1 on the next edge and leave memory, pointers and count unchanged.
REQ-010 SHALL hold overrun at 1 until ovr_clr=1; if ovr_clr and a new overrun occur in the same cycle, overrun SHALL remain 1.
REQ-011 SHALL discard an errored frame when drop_err_en=1, regardless of fill level, and increment drop_cnt by 1, saturating at 255; such a frame SHALL NOT set overrun.
REQ-012 SHALL ignore P_DATA, par_err and stp_err when data_valid=0.
REQ-013 SHALL derive full and empty from count, not from pointer comparison alone.

Reset
REQ-014 SHALL, on RST=1 at a rising CLK edge, set both pointers=0, count=0, overrun=0, drop_cnt=0, which gives empty=1, full=0, rd_valid=0.
REQ-015 SHALL give RST priority over any same-cycle write, read or ovr_clr, including a reset asserted mid-burst; memory contents need not be cleared.
REQ-016 SHALL ignore write requests in the cycle RST=1.

Verification
REQ-017 Single frame: after reset, data_valid with P_DATA=0xA5 and no errors -> next cycle rd_valid=1, rd_data=0xA5, count=1; rd_ready=1 for one cycle -> empty=1.
REQ-018 Fill and wrap: write 0x00..0x07 (DEPTH=8) -> full=1, count=8; read 4 entries, write 0x08..0x0B, then read all -> sequence 0x04..0x0B in order.
REQ-019 Overrun: full FIFO plus data_valid with 0x55 and rd_ready=0 -> overrun=1, count stays 8, 0x55 never read; then ovr_clr=1 -> overrun=0.
REQ-020 Full with simultaneous read and write: head=0x00, write 0x99 while rd_ready=1 -> count stays 8, overrun stays 0, 0x99 is read last.
REQ-021 Error handling: drop_err_en=0 with par_err=1 on 0x3C -> entry read back with rd_par_err=1; drop_err_en=1 with stp_err=1 -> no entry and drop_cnt=1; 256 such drops -> drop_cnt=255.
REQ-022 Reset mid-operation: count=5 and RST=1 coincident with data_valid -> next cycle count=0, empty=1, overrun=0, drop_cnt=0.
